// File: rtl/bcd_conv_sched_pkg.sv
// Shared constants for the round-robin binary-to-BCD converter.
// State encoding and datapath widths live here.
package bcd_conv_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int BIN_W    = 5;
  localparam int DIGIT_W  = 4;
  localparam int ITER     = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/bcd_conv_sched_arb.sv
// Round-robin arbiter: first request at or above ptr_i, with wrap.
// Output is one-hot, or zero when nothing requests.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Multi-requester 5-bit binary to 2-digit BCD converter.
// One request at a time, double-dabble over five cycles.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_val,
  output logic [NREQ-1:0]         req_rdy,
  input  logic [NREQ*BIN_W-1:0]   req_data,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic [IW-1:0]           resp_id,
  output logic [DIGIT_W-1:0]      resp_tens,
  output logic [DIGIT_W-1:0]      resp_ones,
  output logic                    busy
);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      id_q, id_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [2:0]         cnt_q, cnt_d;

  logic [NREQ-1:0]    gnt;
  logic [IW-1:0]      gidx;
  logic [BIN_W-1:0]   sel_data;
  logic [DIGIT_W-1:0] tens_adj, ones_adj;
  logic               accept;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req_i (req_val),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // Held low under reset so nothing looks accepted while rst_n is asserted
  assign req_rdy = (rst_n && state_q == S_IDLE) ? gnt : '0;
  assign accept  = |(req_val & req_rdy);

  always_comb begin
    gidx     = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx     = IW'(i);
        sel_data = req_data[i*BIN_W +: BIN_W];
      end
    end
  end

  assign ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
  assign tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    bin_d   = bin_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (accept) begin
          state_d = S_CONV;
          ptr_d   = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
          id_d    = gidx;
          bin_d   = sel_data;
          tens_d  = '0;
          ones_d  = '0;
          cnt_d   = '0;
        end
      end
      (state_q == S_CONV): begin
        {tens_d, ones_d, bin_d} = {tens_adj, ones_adj, bin_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(ITER-1)) state_d = S_DONE;
      end
      (state_q == S_DONE): begin
        if (resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      bin_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      bin_q   <= bin_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_val  = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign resp_id   = id_q;
  assign resp_tens = tens_q;
  assign resp_ones = ones_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched with a scoreboard of
// expected responses filled at acceptance time.
module tb_bcd_conv_sched;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_val;
  logic [N-1:0]   req_rdy;
  logic [N*5-1:0] req_data;
  logic           resp_val;
  logic           resp_rdy;
  logic [1:0]     resp_id;
  logic [3:0]     resp_tens;
  logic [3:0]     resp_ones;
  logic           busy;

  typedef struct {
    int id;
    int tens;
    int ones;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   mptr     = 0;
  int   acc_cnt  = 0;
  int   last_acc = 0;
  logic prev_val = 1'b0;

  bcd_conv_sched #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_data  (req_data),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_id   (resp_id),
    .resp_tens (resp_tens),
    .resp_ones (resp_ones),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(logic [3:0] v, int p);
    for (int i = 0; i < 4; i++)
      if (v[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  // Monitor: model arbitration, fill scoreboard, check responses
  always @(negedge clk) begin : mon
    int       g;
    int       gi;
    logic [4:0] d;
    exp_t     e;
    if (!rst_n) begin
      prev_val = 1'b0;
    end else begin
      if (|(req_val & req_rdy)) begin
        g = exp_grant(req_val, mptr);
        chk("grant_onehot", 32'(req_rdy), 32'(1 << g));
        d = req_data[g*5 +: 5];
        e.id   = g;
        e.tens = int'(d) / 10;
        e.ones = int'(d) % 10;
        e.acc  = cyc;
        sb.push_back(e);
        gi = -1;
        for (int i = 0; i < N; i++)
          if (req_rdy[i]) gi = i;
        glog.push_back(gi);
        mptr     = (g + 1) % 4;
        acc_cnt++;
        last_acc = cyc;
      end
      if (resp_val && !prev_val) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL spurious_resp observed=1 expected=0");
        end
        if (sb.size() > 0)
          chk("latency", 32'(cyc - sb[0].acc), 32'd6);
      end
      if (resp_val && resp_rdy && sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_tens", 32'(resp_tens), 32'(e.tens));
        chk("resp_ones", 32'(resp_ones), 32'(e.ones));
      end
      prev_val = resp_val;
    end
  end

  task automatic wait_acc(int n0, int n, string tag);
    int t;
    t = 0;
    while (acc_cnt < n0 + n && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 32'(acc_cnt - n0), 32'(n));
  endtask

  task automatic send(int idx, int val);
    int n0;
    n0 = acc_cnt;
    req_data[idx*5 +: 5] = 5'(val);
    req_val[idx] = 1'b1;
    wait_acc(n0, 1, "accept_timeout");
    req_val[idx] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_resp_val"}, 32'(resp_val), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_tens"}, 32'(resp_tens), 32'd0);
    chk({tag, "_ones"}, 32'(resp_ones), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int t;
    int rel;
    int vcnt;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst_n    = 1'b0;
    req_val  = '0;
    req_data = '0;
    resp_rdy = 1'b1;
    #12;
    req_val = '1;
    #1;
    chk_reset_outs("rst0");
    req_val = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Exhaustive sweep on requester 0
    for (int v = 0; v < 32; v++) begin
      send(0, v);
      drain();
    end

    // Fairness from a fresh pointer
    @(posedge clk); #1;
    rst_n = 1'b0;
    mptr  = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_data = {5'd30, 5'd23, 5'd12, 5'd5};
    glog.delete();
    n0 = acc_cnt;
    req_val = '1;
    wait_acc(n0, 5, "fair_accepts");
    req_val = '0;
    drain();
    chk("fair_log_size", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("fair_order", 32'(glog[i]), 32'(exp_order[i]));

    // Backpressure in DONE
    resp_rdy = 1'b0;
    send(2, 19);
    t = 0;
    while (!resp_val && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_resp_seen", 32'(resp_val), 32'd1);
    req_val = 4'b0001;
    repeat (10) begin
      @(negedge clk);
      chk("bp_val", 32'(resp_val), 32'd1);
      chk("bp_id", 32'(resp_id), 32'd2);
      chk("bp_tens", 32'(resp_tens), 32'd1);
      chk("bp_ones", 32'(resp_ones), 32'd9);
      chk("bp_req_rdy", 32'(req_rdy), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    req_val  = '0;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_val_drop", 32'(resp_val), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Pointer wrap: grant 3, then only requester 1
    send(3, 7);
    drain();
    send(1, 10);
    drain();
    chk("wrap_grant", 32'(glog[glog.size()-1]), 32'd1);
    req_data = {5'd4, 5'd22, 5'd15, 5'd8};
    n0 = acc_cnt;
    req_val = 4'b0111;
    wait_acc(n0, 1, "wrap_ptr_accept");
    req_val = '0;
    drain();
    chk("wrap_ptr_next", 32'(glog[glog.size()-1]), 32'd2);

    // Reset during CONV cycle 3
    send(0, 13);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    sb.delete();
    mptr = 0;
    req_data[4:0] = 5'd31;
    req_val = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    n0 = acc_cnt;
    rst_n = 1'b1;
    rel = cyc;
    wait_acc(n0, 1, "post_rst_accept");
    req_val = '0;
    chk("post_rst_first_edge", 32'(last_acc), 32'(rel));
    drain();

    // Idle hold, then confirm pointer kept (expect grant 1)
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || resp_val) vcnt++;
    end
    chk("idle_hold", 32'(vcnt), 32'd0);
    @(posedge clk); #1;
    req_data = {5'd9, 5'd3, 5'd26, 5'd1};
    n0 = acc_cnt;
    req_val = 4'b1011;
    wait_acc(n0, 1, "idle_ptr_accept");
    req_val = '0;
    drain();
    chk("idle_ptr_grant", 32'(glog[glog.size()-1]), 32'd1);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
